alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle execute controller that sits between the instruction source and the 8-bit ALU.
- Accepts one 16-bit instruction per valid/ready handshake and owns a 4x8 register file and the status register (SREG).
- Drives ALU operands and opcode, waits for the ALU's registered result, then writes back the result and the flags.
- Also handles the non-ALU ops LDI and NOP, and flags illegal opcodes.

Parameters:
- ALU_LAT, 1, ALU clock-edge latency from operand sample to valid out/sreg1_o (≥1).
- NREG, 4, register file depth; fixed at 4 by the 2-bit register fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  controller can accept an instruction.
- instr  in  16  [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
- alu_a  out  8  ALU operand a.
- alu_b  out  8  ALU operand b.
- alu_op  out  4  ALU opcode.
- alu_sreg_i  out  8  current SREG presented to the ALU.
- alu_out  in  8  ALU result.
- alu_sreg_o  in  8  ALU updated SREG.
- sreg  out  8  architectural SREG; bit7 N, bit6 V, bit5 Z.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  one-cycle pulse on an illegal opcode.
- dbg_sel  in  2  debug register select.
- dbg_data  out  8  combinational read of R[dbg_sel].

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - R0..R3, sreg, alu_a, alu_b, alu_op, done and err all go to 0.
  - State goes to IDLE.
  - An in-flight instruction is discarded with no writeback and no done.
- States are IDLE, DECODE and EXEC.
- IDLE:
  - instr_ready=1 only in IDLE.
  - instr_valid & instr_ready at an edge latches instr and moves to DECODE.
- DECODE (one cycle), by opcode:
  - Op 0000-0111 (ALU ops):
    - Load alu_op=op and alu_a=R[rd].
    - alu_b=R[rs] for op[2]=0; alu_b=imm for op[2]=1.
    - alu_sreg_i=sreg.
    - Clear the wait counter and go to EXEC.
  - Op 1000 (LDI): R[rd]<=imm; done=1 next cycle; go to IDLE; sreg unchanged.
  - Op 1111 (NOP): done=1; go to IDLE.
  - Op 1001-1110 (illegal): err=1 for one cycle; go to IDLE; no register or sreg change.
- EXEC:
  - alu_a, alu_b, alu_op and alu_sreg_i are held stable for the whole state.
  - The state lasts ALU_LAT+1 cycles: one to present operands, ALU_LAT for the result.
  - On the final edge: R[rd]<=alu_out, sreg<=alu_sreg_o (all 8 bits), done=1 for the following cycle, go to IDLE.
- Timing with ALU_LAT=1:
  - Accept at edge E0; DECODE E0-E1; EXEC E1-E3; writeback at E3.
  - done and instr_ready are high during E3-E4.
  - The next accept is at E4, so back-to-back ALU throughput is 1 instruction per 4 cycles.
  - LDI/NOP take 2 cycles (accept to done).
- Operand registers keep their last values in IDLE and DECODE of non-ALU ops.
- rd==rs is legal: operands are sampled before writeback.
- dbg_data reflects a write on the cycle after the write edge.
- The controller does not interpret flag values; it commits alu_sreg_o verbatim, so flag bits [4:0] pass through via the ALU.
- done and err are never high together.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants: AND, OR, ADD, SUB, ANDI, ORI, ADDI, SUBI, LDI=4'b1000, NOP=4'b1111;
  - instruction field bit positions;
  - state encoding (2-bit);
  - SREG bit indices N=7, V=6, Z=5.
- One sub-module, seq_regfile: 4x8 register file with one synchronous write port, one registered-operand read pair and one combinational debug read, with synchronous reset to 0.

Test Plan:
- Loads and add (behavioural ALU model, ALU_LAT=1):
  - LDI R0,0x05 and LDI R1,0x03 -> dbg R0=0x05, R1=0x03, sreg=0x00.
  - Then ADD R0,R1 -> R0=0x08, Z=0, V=0, done exactly 3 cycles after the accept edge.
- Subtract to zero: SUB R1,R1 with R1=0x03 -> R1=0x00, Z=1, N=0.
- Negative result: SUBI R0,0x09 with R0=0x08 -> R0=0xFF, N=1, Z=0.
- Wrap-around: LDI R2,0xFF; ADDI R2,0x01 -> R2=0x00, Z=1, V=1.
- Illegal opcode 0xA -> err pulse of one cycle, no done, all registers and sreg unchanged, instr_ready=1 the cycle after.
- Reset and throughput:
  - rst_n=0 during the second EXEC cycle of ADD R0,R1 -> R0 keeps its pre-instruction value, sreg=0x00, no done, IDLE.
  - With instr_valid held high, ALU ops are accepted exactly every 4 cycles.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: opcodes, instruction field
// positions, controller state encoding and SREG flag positions.
package alu_seq_pkg;

    localparam int DW = 8;     // datapath / register width
    localparam int IW = 16;    // instruction width

    // Opcodes. Bit 3 clear marks an ALU op, bit 2 selects the immediate operand.
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_ANDI = 4'b0100;
    localparam logic [3:0] OP_ORI  = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b0110;
    localparam logic [3:0] OP_SUBI = 4'b0111;
    localparam logic [3:0] OP_LDI  = 4'b1000;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    // Instruction field bit positions
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 10;
    localparam int RS_HI  = 9;
    localparam int RS_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;
    localparam int OP_IMM_BIT = 2;

    // SREG flag bit indices
    localparam int SREG_N = 7;
    localparam int SREG_V = 6;
    localparam int SREG_Z = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2
    } state_t;

    // ALU ops occupy the lower half of the opcode space.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// Register file: synchronous write port, registered operand pair that
// feeds the ALU, and a combinational debug read.
module seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int NREG = 4
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [1:0]    wr_sel,
    input  logic [DW-1:0] wr_data,
    input  logic          op_load,
    input  logic [1:0]    a_sel,
    input  logic [1:0]    b_sel,
    input  logic          b_use_imm,
    input  logic [DW-1:0] imm,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic [DW-1:0] dbg_data
);

    logic [NREG-1:0][DW-1:0] regs;
    logic [DW-1:0]           op_a_reg;
    logic [DW-1:0]           op_b_reg;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            logic [DW-1:0] q_reg;

            // One register: cleared on reset, loaded when the write port targets it
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (wr_en && (wr_sel == 2'(gi))) begin
                    q_reg <= wr_data;
                end
            end

            assign regs[gi] = q_reg;
        end
    endgenerate

    // Operand pair is captured once per ALU op and then held for the whole execute phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a_reg <= '0;
            op_b_reg <= '0;
        end else if (op_load) begin
            op_a_reg <= regs[a_sel];
            op_b_reg <= b_use_imm ? imm : regs[b_sel];
        end
    end

    assign op_a     = op_a_reg;
    assign op_b     = op_b_reg;
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execute controller: accepts one instruction per handshake,
// drives the external ALU, waits ALU_LAT cycles and writes back result and SREG.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int NREG    = 4
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [IW-1:0] instr,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] alu_sreg_i,
    input  logic [DW-1:0] alu_out,
    input  logic [DW-1:0] alu_sreg_o,
    output logic [DW-1:0] sreg,
    output logic          done,
    output logic          err,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_data
);

    localparam int CW = $clog2(ALU_LAT + 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [IW-1:0] instr_reg;
    logic [3:0]    alu_op_reg;
    logic [DW-1:0] sreg_reg;
    logic          done_reg, err_reg;

    logic          accept, op_load, wr_en, sreg_we, done_next, err_next;
    logic [DW-1:0] wr_data;

    logic [3:0]    op;
    logic [1:0]    rd, rs;
    logic [DW-1:0] imm;

    assign op  = instr_reg[OP_HI:OP_LO];
    assign rd  = instr_reg[RD_HI:RD_LO];
    assign rs  = instr_reg[RS_HI:RS_LO];
    assign imm = instr_reg[IMM_HI:IMM_LO];

    // Next-state and control strobes; the EXEC counter runs 0..ALU_LAT
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        op_load    = 1'b0;
        wr_en      = 1'b0;
        wr_data    = imm;
        sreg_we    = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (instr_valid) begin
                    accept     = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_next = ST_IDLE;
                if (is_alu_op(op)) begin
                    op_load    = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_EXEC;
                end else if (op == OP_LDI) begin
                    wr_en     = 1'b1;
                    wr_data   = imm;
                    done_next = 1'b1;
                end else if (op == OP_NOP) begin
                    done_next = 1'b1;
                end else begin
                    err_next = 1'b1;
                end
            end
            ST_EXEC: begin
                if (cnt_reg == CW'(ALU_LAT)) begin
                    wr_en      = 1'b1;
                    wr_data    = alu_out;
                    sreg_we    = 1'b1;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, latched instruction, opcode, SREG and retire pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            instr_reg  <= '0;
            alu_op_reg <= '0;
            sreg_reg   <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            if (accept) begin
                instr_reg <= instr;
            end
            if (op_load) begin
                alu_op_reg <= op;
            end
            if (sreg_we) begin
                sreg_reg <= alu_sreg_o;
            end
        end
    end

    seq_regfile #(
        .NREG (NREG)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_sel    (rd),
        .wr_data   (wr_data),
        .op_load   (op_load),
        .a_sel     (rd),
        .b_sel     (rs),
        .b_use_imm (op[OP_IMM_BIT]),
        .imm       (imm),
        .dbg_sel   (dbg_sel),
        .op_a      (alu_a),
        .op_b      (alu_b),
        .dbg_data  (dbg_data)
    );

    // SREG only changes at writeback, so it is stable for the whole EXEC state
    assign alu_sreg_i  = sreg_reg;
    assign alu_op      = alu_op_reg;
    assign sreg        = sreg_reg;
    assign done        = done_reg;
    assign err         = err_reg;
    assign instr_ready = (state_reg == ST_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a one-cycle registered ALU model.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_a, alu_b, alu_sreg_i, alu_out, alu_sreg_o, sreg, dbg_data;
    logic [3:0]  alu_op;
    logic        done, err;
    logic [1:0]  dbg_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.ALU_LAT(1), .NREG(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_sreg_i  (alu_sreg_i),
        .alu_out     (alu_out),
        .alu_sreg_o  (alu_sreg_o),
        .sreg        (sreg),
        .done        (done),
        .err         (err),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    // ALU model: V is the carry/borrow out, N and Z from the result, [4:0] passed through.
    function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic [7:0] s);
        logic [8:0] w;
        logic [7:0] r;
        logic [7:0] so;
        logic       v;
        w = '0;
        r = '0;
        v = 1'b0;
        case (op)
            OP_AND, OP_ANDI: r = a & b;
            OP_OR,  OP_ORI:  r = a | b;
            OP_ADD, OP_ADDI: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; v = w[8]; end
            OP_SUB, OP_SUBI: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; v = w[8]; end
            default:         r = '0;
        endcase
        so         = s;
        so[SREG_N] = r[7];
        so[SREG_V] = v;
        so[SREG_Z] = (r == 8'h00);
        return {so, r};
    endfunction

    // Registered ALU, one edge of latency
    always @(posedge clk) begin
        {alu_sreg_o, alu_out} <= alu_model(alu_op, alu_a, alu_b, alu_sreg_i);
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic peek(input logic [1:0] sel, output logic [7:0] val);
        dbg_sel = sel;
        #1;
        val = dbg_data;
    endtask

    // Present an instruction and return just after its accept edge
    task automatic start_instr(input logic [15:0] ins);
        int n;
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {15'd0, instr_ready}, 16'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // Issue an instruction, measure edges from accept to done/err, verify one-cycle pulse
    task automatic run_instr(input string name, input logic [15:0] ins, input int exp_lat,
                             input logic exp_done, input logic exp_err);
        int   lat;
        logic saw_done, saw_err;
        start_instr(ins);
        lat = 0;
        saw_done = 1'b0;
        saw_err  = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (done || err) begin
                lat      = k;
                saw_done = done;
                saw_err  = err;
                break;
            end
        end
        $display("txn %s instr=0x%04h lat=%0d done=%0b err=%0b", name, ins, lat, saw_done, saw_err);
        check({name, "_lat"},  16'(lat), 16'(exp_lat));
        check({name, "_done"}, {15'd0, saw_done}, {15'd0, exp_done});
        check({name, "_err"},  {15'd0, saw_err},  {15'd0, exp_err});
        @(posedge clk);
        #1;
        check({name, "_pulse_end"}, {14'd0, done, err}, 16'd0);
        check({name, "_ready_after"}, {15'd0, instr_ready}, 16'd1);
    endtask

    logic [7:0] v;
    int         acc[4];
    int         nacc;

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_sel     = 2'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sreg",  {8'd0, sreg}, 16'h0000);
        check("rst_done",  {15'd0, done}, 16'd0);
        check("rst_err",   {15'd0, err}, 16'd0);
        check("rst_ready", {15'd0, instr_ready}, 16'd1);
        check("rst_alu",   {alu_a, alu_b}, 16'h0000);
        check("rst_op",    {12'd0, alu_op}, 16'h0000);
        peek(2'd0, v); check("rst_r0", {8'd0, v}, 16'h0000);
        rst_n = 1'b1;

        // Loads and add
        run_instr("ldi_r0", enc(OP_LDI, 2'd0, 2'd0, 8'h05), 1, 1'b1, 1'b0);
        run_instr("ldi_r1", enc(OP_LDI, 2'd1, 2'd0, 8'h03), 1, 1'b1, 1'b0);
        peek(2'd0, v); check("ldi_r0_val", {8'd0, v}, 16'h0005);
        peek(2'd1, v); check("ldi_r1_val", {8'd0, v}, 16'h0003);
        check("ldi_sreg", {8'd0, sreg}, 16'h0000);

        run_instr("add", enc(OP_ADD, 2'd0, 2'd1, 8'h00), 3, 1'b1, 1'b0);
        peek(2'd0, v); check("add_r0", {8'd0, v}, 16'h0008);
        check("add_sreg", {8'd0, sreg}, 16'h0000);
        check("add_operands", {alu_a, alu_b}, 16'h0503);
        check("add_alu_op", {12'd0, alu_op}, 16'h0002);

        // Subtract to zero, rd == rs
        run_instr("sub_zero", enc(OP_SUB, 2'd1, 2'd1, 8'h00), 3, 1'b1, 1'b0);
        peek(2'd1, v); check("sub_r1", {8'd0, v}, 16'h0000);
        check("sub_sreg", {8'd0, sreg}, 16'h0020);

        // Negative result via immediate
        run_instr("subi_neg", enc(OP_SUBI, 2'd0, 2'd0, 8'h09), 3, 1'b1, 1'b0);
        peek(2'd0, v); check("subi_r0", {8'd0, v}, 16'h00FF);
        check("subi_sreg", {8'd0, sreg}, 16'h00C0);

        // Wrap-around
        run_instr("ldi_r2", enc(OP_LDI, 2'd2, 2'd0, 8'hFF), 1, 1'b1, 1'b0);
        run_instr("addi_wrap", enc(OP_ADDI, 2'd2, 2'd0, 8'h01), 3, 1'b1, 1'b0);
        peek(2'd2, v); check("addi_r2", {8'd0, v}, 16'h0000);
        check("addi_sreg", {8'd0, sreg}, 16'h0060);
        check("addi_operands", {alu_a, alu_b}, 16'hFF01);
        check("addi_alu_op", {12'd0, alu_op}, 16'h0006);

        // Illegal opcode: err only, nothing changes
        run_instr("illegal", 16'hA4FF, 1, 1'b0, 1'b1);
        peek(2'd0, v); check("ill_r0", {8'd0, v}, 16'h00FF);
        peek(2'd1, v); check("ill_r1", {8'd0, v}, 16'h0000);
        peek(2'd2, v); check("ill_r2", {8'd0, v}, 16'h0000);
        peek(2'd3, v); check("ill_r3", {8'd0, v}, 16'h0000);
        check("ill_sreg", {8'd0, sreg}, 16'h0060);

        run_instr("nop", enc(OP_NOP, 2'd0, 2'd0, 8'h00), 1, 1'b1, 1'b0);
        check("nop_sreg", {8'd0, sreg}, 16'h0060);

        // Reset during second EXEC cycle of ADD R0,R1
        run_instr("sub_r0", enc(OP_SUB, 2'd0, 2'd0, 8'h00), 3, 1'b1, 1'b0);
        run_instr("ldi_r1b", enc(OP_LDI, 2'd1, 2'd0, 8'h03), 1, 1'b1, 1'b0);
        check("pre_rst_sreg", {8'd0, sreg}, 16'h0020);
        start_instr(enc(OP_ADD, 2'd0, 2'd1, 8'h00));
        @(posedge clk); #1;     // E1: enter EXEC
        @(posedge clk); #1;     // E2: second EXEC cycle
        rst_n = 1'b0;
        @(posedge clk); #1;     // E3: reset wins over writeback
        $display("txn reset_in_exec instr=0x%04h done=%0b ready=%0b", instr, done, instr_ready);
        check("midrst_done",  {15'd0, done}, 16'd0);
        check("midrst_ready", {15'd0, instr_ready}, 16'd1);
        check("midrst_sreg",  {8'd0, sreg}, 16'h0000);
        peek(2'd0, v); check("midrst_r0", {8'd0, v}, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_done_after", {15'd0, done}, 16'd0);

        // Throughput with instr_valid held high: ADD R1,R1 from R1=1
        run_instr("ldi_r1c", enc(OP_LDI, 2'd1, 2'd0, 8'h01), 1, 1'b1, 1'b0);
        @(negedge clk);
        instr       = enc(OP_ADD, 2'd1, 2'd1, 8'h00);
        instr_valid = 1'b1;
        nacc = 0;
        for (int c = 0; c < 16; c++) begin
            if (instr_ready) begin
                if (nacc < 4) acc[nacc] = c;
                nacc++;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        $display("txn burst accepts=%0d at %0d %0d %0d %0d", nacc, acc[0], acc[1], acc[2], acc[3]);
        check("burst_count", 16'(nacc), 16'd4);
        for (int i = 1; i < 4; i++) begin
            check("burst_spacing", 16'(acc[i] - acc[i-1]), 16'd4);
        end
        repeat (8) @(posedge clk);
        #1;
        peek(2'd1, v); check("burst_r1", {8'd0, v}, 16'h0010);
        check("burst_sreg", {8'd0, sreg}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
